// File: rtl/exu_alu_arb.sv
// exu_alu_arb: shares the execute-stage ALU between the main EXU operand path
// (req0) and an auxiliary requester (req1). A round-robin arbiter picks one
// requester, the operands are latched, the ALU is driven for one cycle, and the
// registered result is held until the owning requester takes it.
module exu_alu_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ARGS_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [ARGS_WIDTH-1:0] i_req0_alu_type,
    input  logic [DATA_WIDTH-1:0] i_req0_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_req0_rs2_data,

    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [ARGS_WIDTH-1:0] i_req1_alu_type,
    input  logic [DATA_WIDTH-1:0] i_req1_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_req1_rs2_data,

    output logic                  o_rsp0_valid,
    input  logic                  i_rsp0_ready,
    output logic                  o_rsp1_valid,
    input  logic                  i_rsp1_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_res,
    output logic                  o_rsp_zero,
    output logic                  o_rsp_over,
    output logic                  o_rsp_nega,

    output logic [ARGS_WIDTH-1:0] o_alu_type,
    output logic [DATA_WIDTH-1:0] o_alu_rs1_data,
    output logic [DATA_WIDTH-1:0] o_alu_rs2_data,
    input  logic [DATA_WIDTH-1:0] i_alu_res,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_over,
    input  logic                  i_alu_nega,

    output logic                  o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_q;       // 0: req0 preferred on a tie
    logic                  owner_q;    // requester that owns the in-flight op
    logic [ARGS_WIDTH-1:0] type_q;
    logic [DATA_WIDTH-1:0] rs1_q, rs2_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  zero_q, over_q, nega_q;

    logic                  grant0, grant1;
    logic                  acc0, acc1;
    logic                  rsp_hs;

    // Round-robin grant: a lone valid wins, a tie goes to the pointer.
    always_comb begin
        grant0 = i_req0_valid && (!i_req1_valid || !rr_q);
        grant1 = i_req1_valid && (!i_req0_valid || rr_q);
    end

    // Ready is gated by reset so every output is 0 while reset is held,
    // even though IDLE is the reset state and valids may still be high.
    assign o_req0_ready = i_rst_n && (state_q == IDLE) && grant0;
    assign o_req1_ready = i_rst_n && (state_q == IDLE) && grant1;
    assign acc0         = o_req0_ready;
    assign acc1         = o_req1_ready;

    // Only the owner's response ready can release RESP.
    assign rsp_hs = (state_q == RESP) && (owner_q ? i_rsp1_ready : i_rsp0_ready);

    // Next-state logic: IDLE -> EXEC on accept, EXEC always one cycle,
    // RESP held until the owner takes the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc0 || acc1) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // On accept: latch operands, record owner, point rr at the other requester.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            type_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else if (acc0 || acc1) begin
            rr_q    <= !acc1;
            owner_q <= acc1;
            type_q  <= acc1 ? i_req1_alu_type : i_req0_alu_type;
            rs1_q   <= acc1 ? i_req1_rs1_data : i_req0_rs1_data;
            rs2_q   <= acc1 ? i_req1_rs2_data : i_req0_rs2_data;
        end
    end

    // Capture ALU result and flags at the end of EXEC; held until the next EXEC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            over_q <= 1'b0;
            nega_q <= 1'b0;
        end else if (state_q == EXEC) begin
            res_q  <= i_alu_res;
            zero_q <= i_alu_zero;
            over_q <= i_alu_over;
            nega_q <= i_alu_nega;
        end
    end

    // ALU operands are only driven during EXEC so the shared ALU sees zeros otherwise.
    always_comb begin
        o_alu_type     = '0;
        o_alu_rs1_data = '0;
        o_alu_rs2_data = '0;
        if (state_q == EXEC) begin
            o_alu_type     = type_q;
            o_alu_rs1_data = rs1_q;
            o_alu_rs2_data = rs2_q;
        end
    end

    assign o_rsp0_valid = (state_q == RESP) && !owner_q;
    assign o_rsp1_valid = (state_q == RESP) &&  owner_q;
    assign o_rsp_res    = res_q;
    assign o_rsp_zero   = zero_q;
    assign o_rsp_over   = over_q;
    assign o_rsp_nega   = nega_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_exu_alu_arb.sv
// Bench for exu_alu_arb: directed requests with hand-computed results pushed
// into a scoreboard; a negedge monitor pops and compares on each response handshake.
module tb_exu_alu_arb;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam logic [AW-1:0] OP_ADD = 4'd0;
    localparam logic [AW-1:0] OP_SUB = 4'd1;

    logic          i_clk, i_rst_n;
    logic          r0_valid, r1_valid;
    logic          o_req0_ready, o_req1_ready;
    logic [AW-1:0] r0_type, r1_type;
    logic [DW-1:0] r0_rs1, r0_rs2, r1_rs1, r1_rs2;
    logic          o_rsp0_valid, o_rsp1_valid;
    logic          i_rsp0_ready, i_rsp1_ready;
    logic [DW-1:0] o_rsp_res;
    logic          o_rsp_zero, o_rsp_over, o_rsp_nega;
    logic [AW-1:0] o_alu_type;
    logic [DW-1:0] o_alu_rs1_data, o_alu_rs2_data;
    logic [DW-1:0] alu_res;
    logic          alu_zero, alu_over, alu_nega;
    logic          o_busy;

    typedef struct packed {
        logic          owner;
        logic [DW-1:0] res;
        logic          zero;
        logic          over;
        logic          nega;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    exu_alu_arb #(.DATA_WIDTH(DW), .ARGS_WIDTH(AW)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_req0_valid    (r0_valid),
        .o_req0_ready    (o_req0_ready),
        .i_req0_alu_type (r0_type),
        .i_req0_rs1_data (r0_rs1),
        .i_req0_rs2_data (r0_rs2),
        .i_req1_valid    (r1_valid),
        .o_req1_ready    (o_req1_ready),
        .i_req1_alu_type (r1_type),
        .i_req1_rs1_data (r1_rs1),
        .i_req1_rs2_data (r1_rs2),
        .o_rsp0_valid    (o_rsp0_valid),
        .i_rsp0_ready    (i_rsp0_ready),
        .o_rsp1_valid    (o_rsp1_valid),
        .i_rsp1_ready    (i_rsp1_ready),
        .o_rsp_res       (o_rsp_res),
        .o_rsp_zero      (o_rsp_zero),
        .o_rsp_over      (o_rsp_over),
        .o_rsp_nega      (o_rsp_nega),
        .o_alu_type      (o_alu_type),
        .o_alu_rs1_data  (o_alu_rs1_data),
        .o_alu_rs2_data  (o_alu_rs2_data),
        .i_alu_res       (alu_res),
        .i_alu_zero      (alu_zero),
        .i_alu_over      (alu_over),
        .i_alu_nega      (alu_nega),
        .o_busy          (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Stand-in ALU: ADD/SUB with signed-overflow, zero and negative flags.
    always_comb begin
        alu_res  = '0;
        alu_over = 1'b0;
        case (o_alu_type)
            OP_ADD: begin
                alu_res  = o_alu_rs1_data + o_alu_rs2_data;
                alu_over = (o_alu_rs1_data[DW-1] == o_alu_rs2_data[DW-1]) &&
                           (alu_res[DW-1] != o_alu_rs1_data[DW-1]);
            end
            OP_SUB: begin
                alu_res  = o_alu_rs1_data - o_alu_rs2_data;
                alu_over = (o_alu_rs1_data[DW-1] != o_alu_rs2_data[DW-1]) &&
                           (alu_res[DW-1] != o_alu_rs1_data[DW-1]);
            end
            default: alu_res = '0;
        endcase
        alu_zero = (alu_res == '0);
        alu_nega = alu_res[DW-1];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input logic own);
        exp_t a, e;
        a = {own, o_rsp_res, o_rsp_zero, o_rsp_over, o_rsp_nega};
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: got owner=%0d res=0x%0h with empty scoreboard", own, o_rsp_res);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL rsp_data: got owner=%0d res=0x%0h z=%0d o=%0d n=%0d expected owner=%0d res=0x%0h z=%0d o=%0d n=%0d",
                         a.owner, a.res, a.zero, a.over, a.nega, e.owner, e.res, e.zero, e.over, e.nega);
            end
        end
    endtask

    // Monitor: compare against the scoreboard on every response handshake.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_rsp0_valid && i_rsp0_ready) check_rsp(1'b0);
            if (o_rsp1_valid && i_rsp1_ready) check_rsp(1'b1);
        end
    end

    task automatic push(input logic own, input logic [DW-1:0] res,
                        input logic z, input logic o, input logic n);
        exp_t e;
        e = {own, res, z, o, n};
        sb.push_back(e);
    endtask

    // Present one op on requester n, hold until accepted, then drop valid.
    task automatic req_op(input bit n, input logic [AW-1:0] t,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit done = 1'b0;
        if (!n) begin r0_valid = 1'b1; r0_type = t; r0_rs1 = a; r0_rs2 = b; end
        else    begin r1_valid = 1'b1; r1_type = t; r1_rs1 = a; r1_rs2 = b; end
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge i_clk);
            done = n ? o_req1_ready : o_req0_ready;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL req%0d_accept_timeout: got no ready expected ready within 50 cycles", n);
        end
        @(posedge i_clk); #1;
        if (!n) r0_valid = 1'b0; else r1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge i_clk);
            done = !o_busy;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within 50 cycles");
        end
        @(posedge i_clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req0_ready"}, o_req0_ready, 0);
        chk({tag, "_req1_ready"}, o_req1_ready, 0);
        chk({tag, "_rsp0_valid"}, o_rsp0_valid, 0);
        chk({tag, "_rsp1_valid"}, o_rsp1_valid, 0);
        chk({tag, "_rsp_res"},    o_rsp_res, 0);
        chk({tag, "_rsp_flags"},  {o_rsp_zero, o_rsp_over, o_rsp_nega}, 0);
        chk({tag, "_alu_type"},   o_alu_type, 0);
        chk({tag, "_alu_rs1"},    o_alu_rs1_data, 0);
        chk({tag, "_alu_rs2"},    o_alu_rs2_data, 0);
        chk({tag, "_busy"},       o_busy, 0);
    endtask

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0;
        r0_valid = 1'b0; r0_type = '0; r0_rs1 = '0; r0_rs2 = '0;
        r1_valid = 1'b0; r1_type = '0; r1_rs1 = '0; r1_rs2 = '0;
        i_rsp0_ready = 1'b1;
        i_rsp1_ready = 1'b1;
        #3;
        chk_all_zero("reset");
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Single request: req0 ADD 5+3, cycle-by-cycle.
        push(1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        r0_valid = 1'b1; r0_type = OP_ADD; r0_rs1 = 32'h5; r0_rs2 = 32'h3;
        @(negedge i_clk);
        chk("single_c0_req0_ready", o_req0_ready, 1);
        chk("single_c0_req1_ready", o_req1_ready, 0);
        chk("single_c0_alu_type",   o_alu_type, 0);
        @(posedge i_clk); #1;
        r0_valid = 1'b0;
        @(negedge i_clk);
        chk("single_c1_alu_type",   o_alu_type, OP_ADD);
        chk("single_c1_alu_rs1",    o_alu_rs1_data, 32'h5);
        chk("single_c1_alu_rs2",    o_alu_rs2_data, 32'h3);
        chk("single_c1_busy",       o_busy, 1);
        chk("single_c1_rsp0_valid", o_rsp0_valid, 0);
        @(negedge i_clk);
        chk("single_c2_rsp0_valid", o_rsp0_valid, 1);
        chk("single_c2_rsp1_valid", o_rsp1_valid, 0);
        chk("single_c2_rsp_res",    o_rsp_res, 32'h8);
        chk("single_c2_alu_type",   o_alu_type, 0);
        @(posedge i_clk); #1;
        wait_idle();

        // Flags.
        push(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        req_op(1'b1, OP_SUB, 32'h8000_0000, 32'h0000_0001);
        wait_idle();
        push(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        req_op(1'b1, OP_SUB, 32'h0000_1234, 32'h0000_1234);
        wait_idle();
        push(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        req_op(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_idle();

        // Backpressure on rsp1 with req0 waiting; rsp0_ready=1 is misrouted.
        i_rsp1_ready = 1'b0;
        push(1'b1, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
        r1_valid = 1'b1; r1_type = OP_ADD; r1_rs1 = 32'h10; r1_rs2 = 32'h20;
        @(negedge i_clk);
        chk("bp_req1_ready", o_req1_ready, 1);
        @(posedge i_clk); #1;
        r1_valid = 1'b0;
        push(1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        r0_valid = 1'b1; r0_type = OP_ADD; r0_rs1 = 32'h1; r0_rs2 = 32'h1;
        @(posedge i_clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            chk("bp_rsp1_valid",  o_rsp1_valid, 1);
            chk("bp_rsp0_valid",  o_rsp0_valid, 0);
            chk("bp_rsp_res",     o_rsp_res, 32'h30);
            chk("bp_req0_ready",  o_req0_ready, 0);
            chk("bp_busy",        o_busy, 1);
            @(posedge i_clk); #1;
        end
        i_rsp1_ready = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("bp_release_busy",       o_busy, 0);
        chk("bp_release_req0_ready", o_req0_ready, 1);
        chk("bp_hold_rsp_res",       o_rsp_res, 32'h30);
        @(posedge i_clk); #1;
        r0_valid = 1'b0;
        wait_idle();

        // Reset during RESP drops the op and clears everything at once.
        i_rsp0_ready = 1'b0;
        r0_valid = 1'b1; r0_type = OP_ADD; r0_rs1 = 32'h7; r0_rs2 = 32'h7;
        @(negedge i_clk);
        chk("mid_accept_req0_ready", o_req0_ready, 1);
        @(posedge i_clk); #1;
        r0_valid = 1'b0;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("mid_rsp0_valid", o_rsp0_valid, 1);
        chk("mid_rsp_res",    o_rsp_res, 32'hE);
        r0_valid = 1'b1; r1_valid = 1'b1;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        r0_valid = 1'b0; r1_valid = 1'b0;
        i_rsp0_ready = 1'b1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Both requesters continuously valid after reset: grants go 0,1,0,1.
        push(1'b0, 32'h0000_0123, 1'b0, 1'b0, 1'b0);
        push(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        push(1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        push(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        fork
            begin
                req_op(1'b0, OP_ADD, 32'h0000_0100, 32'h0000_0023);
                req_op(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
            end
            begin
                req_op(1'b1, OP_SUB, 32'h0000_0005, 32'h0000_0007);
                req_op(1'b1, OP_SUB, 32'h0000_0009, 32'h0000_0009);
            end
        join
        wait_idle();

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
